// File: rtl/dma_byte_packer.sv
// Packs little-endian byte writes from an Avalon DMA master into 32-bit words and buffers them in a small FIFO.
// Latency: 1 cycle from the lane-3 write edge to out_valid.
// Backpressure: s_waitrequest stalls all byte lanes while the FIFO is full; out_ready pops the head.
module dma_byte_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        clear,
    input  logic [4:0]  s_address,
    input  logic        s_chipselect,
    input  logic        s_write_n,
    input  logic [7:0]  s_writedata,
    output logic        s_waitrequest,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic [15:0] word_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    logic [31:0]   mem [FIFO_DEPTH];
    logic [23:0]   assembly;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   occupancy;

    logic          full;
    logic          wr_acc;
    logic          push;
    logic          pop;
    logic [1:0]    lane;
    logic [31:0]   push_dat;
    logic [PW-1:0] rd_ptr_nxt;
    logic [PW:0]   occupancy_nxt;
    logic [31:0]   head_nxt;
    logic          unused_addr;

    assign unused_addr   = ^s_address[4:2];
    assign lane          = s_address[1:0];
    assign full          = (occupancy == FULL_CNT);
    assign s_waitrequest = full | ~clk_en | ~aclr;
    assign wr_acc        = clk_en & s_chipselect & ~s_write_n & ~s_waitrequest;
    assign push          = wr_acc & (lane == 2'd3);
    assign pop           = clk_en & out_valid & out_ready;
    assign push_dat      = {s_writedata, assembly};

    // The head after this edge is the word being written now only when it lands at the new read pointer.
    always_comb begin
        rd_ptr_nxt    = pop ? rd_ptr + 1'b1 : rd_ptr;
        occupancy_nxt = occupancy;
        if (push && !pop)
            occupancy_nxt = occupancy + 1'b1;
        else if (pop && !push)
            occupancy_nxt = occupancy - 1'b1;
        head_nxt = (push && (wr_ptr == rd_ptr_nxt)) ? push_dat : mem[rd_ptr_nxt];
    end

    always_ff @(posedge clock) begin
        if (push && !clear)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clock or negedge aclr) begin
        if (!aclr) begin
            assembly   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            word_count <= '0;
        end else if (clk_en) begin
            if (clear) begin
                assembly   <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                occupancy  <= '0;
                out_valid  <= 1'b0;
                word_count <= '0;
            end else begin
                if (wr_acc) begin
                    case (lane)
                        2'd0:    assembly[7:0]   <= s_writedata;
                        2'd1:    assembly[15:8]  <= s_writedata;
                        2'd2:    assembly[23:16] <= s_writedata;
                        default: ;
                    endcase
                end
                if (push) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    word_count <= word_count + 16'd1;
                end
                rd_ptr    <= rd_ptr_nxt;
                occupancy <= occupancy_nxt;
                out_valid <= (occupancy_nxt != '0);
                // Empty FIFO keeps the last word on out_data.
                if (occupancy_nxt != '0)
                    out_data <= head_nxt;
            end
        end
    end

endmodule

// File: tb/tb_dma_byte_packer.sv
// Directed bench for dma_byte_packer with FIFO_DEPTH=4.
module tb_dma_byte_packer;

    logic        clock = 1'b0;
    logic        aclr;
    logic        clk_en;
    logic        clear;
    logic [4:0]  s_address;
    logic        s_chipselect;
    logic        s_write_n;
    logic [7:0]  s_writedata;
    logic        s_waitrequest;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [15:0] word_count;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    dma_byte_packer #(.FIFO_DEPTH(4)) dut (
        .clock(clock),
        .aclr(aclr),
        .clk_en(clk_en),
        .clear(clear),
        .s_address(s_address),
        .s_chipselect(s_chipselect),
        .s_write_n(s_write_n),
        .s_writedata(s_writedata),
        .s_waitrequest(s_waitrequest),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .word_count(word_count)
    );

    task automatic do_write(input logic [1:0] lane, input logic [7:0] d);
        s_address    = {3'b000, lane};
        s_writedata  = d;
        s_chipselect = 1'b1;
        s_write_n    = 1'b0;
        @(posedge clock); #1;
        s_chipselect = 1'b0;
        s_write_n    = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clock); #1;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        aclr = 1'b0;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=00000000", out_data); end
        total++; if (word_count !== 16'h0) begin bad++; $display("FAIL reset_count got=%h want=0000", word_count); end
        total++; if (s_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_wait got=%b want=1", s_waitrequest); end
        @(posedge clock); #1;
        aclr = 1'b1;
    endtask

    task automatic test_basic();
        do_clear();
        out_ready = 1'b1;
        do_write(2'd0, 8'h78);
        do_write(2'd1, 8'h56);
        do_write(2'd2, 8'h34);
        do_write(2'd3, 8'h12);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", out_valid); end
        total++; if (out_data !== 32'h12345678) begin bad++; $display("FAIL basic_data got=%h want=12345678", out_data); end
        total++; if (word_count !== 16'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", word_count); end
        @(posedge clock); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_popped got=%b want=0", out_valid); end
        total++; if (out_data !== 32'h12345678) begin bad++; $display("FAIL basic_hold got=%h want=12345678", out_data); end
    endtask

    task automatic test_full();
        logic [31:0] exp_w [5];
        do_clear();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_write(2'd0, 8'h10 + 8'(i));
            do_write(2'd3, 8'hA0 + 8'(i));
            exp_w[i] = {8'hA0 + 8'(i), 16'h0000, 8'h10 + 8'(i)};
        end
        exp_w[4] = 32'hA4000015;
        total++; if (s_waitrequest !== 1'b1) begin bad++; $display("FAIL full_wait got=%b want=1", s_waitrequest); end
        total++; if (word_count !== 16'd4) begin bad++; $display("FAIL full_count got=%0d want=4", word_count); end
        total++; if (out_data !== exp_w[0]) begin bad++; $display("FAIL full_head got=%h want=%h", out_data, exp_w[0]); end
        s_address = 5'd0; s_writedata = 8'h15; s_chipselect = 1'b1; s_write_n = 1'b0;
        @(posedge clock); #1;
        total++; if (s_waitrequest !== 1'b1) begin bad++; $display("FAIL full_held got=%b want=1", s_waitrequest); end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        total++; if (out_data !== exp_w[1]) begin bad++; $display("FAIL full_pop_head got=%h want=%h", out_data, exp_w[1]); end
        total++; if (s_waitrequest !== 1'b0) begin bad++; $display("FAIL full_wait_drop got=%b want=0", s_waitrequest); end
        @(posedge clock); #1;
        s_chipselect = 1'b0; s_write_n = 1'b1;
        do_write(2'd3, 8'hA4);
        total++; if (word_count !== 16'd5) begin bad++; $display("FAIL full_count5 got=%0d want=5", word_count); end
        out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_w[k]) begin
                bad++; $display("FAIL full_drain%0d got=%b/%h want=1/%h", k, out_valid, out_data, exp_w[k]);
            end
            @(posedge clock); #1;
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_clear();
        do_clear();
        out_ready = 1'b0;
        do_write(2'd0, 8'h99);
        do_write(2'd3, 8'h01);
        do_write(2'd3, 8'h02);
        total++; if (word_count !== 16'd2) begin bad++; $display("FAIL clr_pre_count got=%0d want=2", word_count); end
        s_address = 5'd3; s_writedata = 8'h03; s_chipselect = 1'b1; s_write_n = 1'b0; clear = 1'b1;
        @(posedge clock); #1;
        s_chipselect = 1'b0; s_write_n = 1'b1; clear = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b want=0", out_valid); end
        total++; if (word_count !== 16'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", word_count); end
        @(posedge clock); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_no_push got=%b want=0", out_valid); end
        do_write(2'd3, 8'h44);
        total++; if (out_data !== 32'h44000000) begin bad++; $display("FAIL clr_asm_zero got=%h want=44000000", out_data); end
        total++; if (word_count !== 16'd1) begin bad++; $display("FAIL clr_count1 got=%0d want=1", word_count); end
    endtask

    task automatic test_clk_en();
        do_clear();
        out_ready = 1'b0;
        clk_en = 1'b0;
        #1;
        total++; if (s_waitrequest !== 1'b1) begin bad++; $display("FAIL en_wait got=%b want=1", s_waitrequest); end
        do_write(2'd3, 8'h55);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL en_valid got=%b want=0", out_valid); end
        total++; if (word_count !== 16'd0) begin bad++; $display("FAIL en_count got=%0d want=0", word_count); end
        clk_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_clear();
        out_ready = 1'b0;
        do_write(2'd3, 8'h77);
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'h22);
        aclr = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL mid_data got=%h want=00000000", out_data); end
        total++; if (word_count !== 16'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", word_count); end
        total++; if (s_waitrequest !== 1'b1) begin bad++; $display("FAIL mid_wait got=%b want=1", s_waitrequest); end
        @(posedge clock); #1;
        aclr = 1'b1;
        do_write(2'd0, 8'hAA);
        do_write(2'd1, 8'hBB);
        do_write(2'd2, 8'hCC);
        do_write(2'd3, 8'hDD);
        total++; if (out_valid !== 1'b1 || out_data !== 32'hDDCCBBAA) begin
            bad++; $display("FAIL mid_word got=%b/%h want=1/ddccbbaa", out_valid, out_data);
        end
        total++; if (word_count !== 16'd1) begin bad++; $display("FAIL mid_count1 got=%0d want=1", word_count); end
    endtask

    task automatic test_wrap();
        logic [31:0] sb [$];
        logic        popping;
        int          errs = 0;
        do_clear();
        out_ready = 1'b1;
        do_write(2'd0, 8'h0A);
        do_write(2'd1, 8'h0B);
        do_write(2'd2, 8'h0C);
        s_address = 5'd3; s_chipselect = 1'b1; s_write_n = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            s_writedata = 8'(i) ^ 8'h5A;
            popping = out_valid;
            @(posedge clock); #1;
            if (popping) void'(sb.pop_front());
            sb.push_back({8'(i) ^ 8'h5A, 24'h0C0B0A});
            if (out_valid !== 1'b1 || out_data !== sb[0]) errs++;
        end
        s_chipselect = 1'b0; s_write_n = 1'b1;
        @(posedge clock); #1;
        void'(sb.pop_front());
        total++; if (errs !== 0) begin bad++; $display("FAIL wrap_stream got=%0d mismatched words want=0", errs); end
        total++; if (out_valid !== 1'b0 || sb.size() != 0) begin
            bad++; $display("FAIL wrap_drain got=%b/%0d want=0/0", out_valid, sb.size());
        end
        total++; if (word_count !== 16'h0001) begin bad++; $display("FAIL wrap_count got=%h want=0001", word_count); end
    endtask

    initial begin
        aclr = 1'b0; clk_en = 1'b1; clear = 1'b0;
        s_address = '0; s_chipselect = 1'b0; s_write_n = 1'b1; s_writedata = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_clear();
        test_clk_en();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dma_byte_packer.md
DMA_BYTE_PACKER -- requirements
Module: dma_byte_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 32-bit word entries buffered; legal values are powers of two, 2..16.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port aclr, input, 1, asynchronous active-low reset (0 = reset).
REQ-004 SHALL have port clk_en, input, 1, global enable; when 0, all state holds.
REQ-005 SHALL have port clear, input, 1, synchronous flush pulse issued before each new array transfer.
REQ-006 SHALL have port s_address, input, 5, Avalon slave address from the DMA write master; only bits [1:0] are used, as the byte lane.
REQ-007 SHALL have port s_chipselect, input, 1, Avalon slave select.
REQ-008 SHALL have port s_write_n, input, 1, Avalon write strobe, active-low.
REQ-009 SHALL have port s_writedata, input, 8, write byte.
REQ-010 SHALL have port s_waitrequest, output, 1, Avalon stall to the DMA write master.
REQ-011 SHALL have port out_valid, output, 1, a packed word is available to the CORDIC stage.
REQ-012 SHALL have port out_data, output, 32, the packed word at the FIFO head.
REQ-013 SHALL have port out_ready, input, 1, the CORDIC stage accepts out_data.
REQ-014 SHALL have port word_count, output, 16, number of words pushed since the last clear.

Function
REQ-015 SHALL accept a byte write in a cycle where clk_en=1, s_chipselect=1, s_write_n=0 and s_waitrequest=0; no other cycle is a write.
REQ-016 SHALL store an accepted byte into assembly-register lane s_address[1:0], at bits [8*lane+7 : 8*lane] (little-endian).
REQ-017 SHALL push {s_writedata, assembly[23:0]} into the FIFO in the same edge that accepts a lane-3 write. The assembly register is not cleared, so stale lanes persist.
REQ-018 SHALL drive s_waitrequest=1 combinationally whenever the FIFO is full, clk_en=0, or aclr=0; otherwise 0. A pop in the same cycle does not lift the stall (no full-bypass).
REQ-019 SHALL stall lane-0..2 writes as well as lane-3 writes when the FIFO is full.
REQ-020 SHALL pop the head entry on an edge where clk_en=1, out_valid=1 and out_ready=1.
REQ-021 SHALL drive out_valid=1 iff the FIFO is non-empty, and out_data equal to the head entry, both registered. out_data is undefined-but-stable (holds last value) when empty.
REQ-022 SHALL have a latency of 1 cycle: a lane-3 write accepted at edge N gives out_valid=1 after edge N.
REQ-023 SHALL leave the occupancy unchanged on a simultaneous push and pop when not full. Pointers wrap modulo FIFO_DEPTH.
REQ-024 SHALL increment word_count by 1 per push, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL, on clear=1 with clk_en=1, empty the FIFO, zero word_count and zero the assembly register. clear SHALL take priority over a simultaneous push or pop, and that push or pop SHALL be discarded.
REQ-026 SHALL ignore out_ready while out_valid=0, and SHALL ignore s_writedata on non-accepted cycles.

Reset
REQ-027 SHALL, while aclr=0, force out_valid=0, out_data=0, word_count=0, the assembly register to 0, the FIFO pointers and occupancy to 0, and s_waitrequest=1.
REQ-028 SHALL, on reset asserted mid-transfer, discard partial words and buffered words; after release the block is empty and accepts writes on the next edge.

Verification
REQ-029 Bytes 0x78,0x56,0x34,0x12 written to addresses 0..3, with out_ready=1 -> one cycle after the lane-3 write, out_valid=1 and out_data=0x12345678; word_count=1.
REQ-030 With out_ready=0 and FIFO_DEPTH=4, push 4 words -> s_waitrequest=1; a 5th write is held. Raise out_ready for one cycle -> one pop; s_waitrequest drops the next cycle and the held write completes.
REQ-031 With the FIFO full, out_ready=1 and a write pending in the same cycle -> the pop occurs and the write is stalled exactly that cycle.
REQ-032 Assert clear in the same cycle as a lane-3 write with 2 words buffered -> the FIFO is empty next cycle, out_valid=0, word_count=0, and no word is pushed.
REQ-033 Pull aclr low after lane 1 of a word -> outputs at reset values. After release, write lanes 0..3 = 0xAA,0xBB,0xCC,0xDD -> out_data=0xDDCCBBAA.
REQ-034 Run 65537 words through -> word_count=0x0001, and every out_data matches its scoreboard entry in order.
